bunny_hit_judge: RTL and testbench

//   Consumer side of the bunny position stream: latches the 4-bit bunny position

---
 rtl/bunny_hit_judge.sv | 105 ++++++++++
 tb/tb_bunny_hit_judge.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bunny_hit_judge.sv
// Latches the bunny position, drives the LED one-hot, and judges presses against the latched target.
// Tracks score and lives; hit/miss are held for HOLD_CYC cycles, then the game re-arms or ends.
module bunny_hit_judge #(
   parameter int POS_W    = 4,
   parameter int SCORE_W  = 8,
   parameter int LIVES    = 3,
   parameter int HOLD_CYC = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  pos_valid,
   input  logic [POS_W-1:0]      pos,
   input  logic                  press,
   input  logic [POS_W-1:0]      guess,
   output logic [2**POS_W-1:0]   bunny_onehot,
   output logic                  hit,
   output logic                  miss,
   output logic [SCORE_W-1:0]    score,
   output logic [1:0]            lives,
   output logic                  game_over
);

   localparam int ONE_W = 2**POS_W;
   localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

   typedef enum logic [2:0] {IDLE, ARMED, HIT_S, MISS_S, OVER} state_t;

   state_t           state;
   logic [POS_W-1:0] target;
   logic [CNT_W-1:0] hold_cnt;
   logic             active;

   assign active = (state == ARMED) || (state == HIT_S) || (state == MISS_S);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         target       <= '0;
         bunny_onehot <= '0;
         hit          <= 1'b0;
         miss         <= 1'b0;
         score        <= '0;
         lives        <= LIVES_INIT;
         game_over    <= 1'b0;
         hold_cnt     <= '0;
      end else begin
         // The press below still compares against the old target register value.
         if (active && pos_valid) begin
            target       <= pos;
            bunny_onehot <= ONE_W'(1) << pos;
         end

         if (start) begin
            state        <= ARMED;
            score        <= '0;
            lives        <= LIVES_INIT;
            hit          <= 1'b0;
            miss         <= 1'b0;
            game_over    <= 1'b0;
            hold_cnt     <= '0;
            bunny_onehot <= ONE_W'(1) << ((active && pos_valid) ? pos : target);
         end else begin
            case (state)
               ARMED: begin
                  if (press) begin
                     hold_cnt <= HOLD_LAST;
                     if (guess == target) begin
                        state <= HIT_S;
                        hit   <= 1'b1;
                        if (score != '1)
                           score <= score + SCORE_W'(1);
                     end else begin
                        state <= MISS_S;
                        miss  <= 1'b1;
                        lives <= lives - 2'd1;
                     end
                  end
               end
               HIT_S, MISS_S: begin
                  if (hold_cnt == '0) begin
                     hit  <= 1'b0;
                     miss <= 1'b0;
                     // lives was already decremented on MISS entry.
                     if (state == MISS_S && lives == 2'd0) begin
                        state        <= OVER;
                        game_over    <= 1'b1;
                        bunny_onehot <= '0;
                     end else begin
                        state <= ARMED;
                     end
                  end else begin
                     hold_cnt <= hold_cnt - CNT_W'(1);
                  end
               end
               IDLE, OVER: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bunny_hit_judge.sv
// Directed and random stimulus against a cycle-level game model of bunny_hit_judge.
module tb_bunny_hit_judge;

   logic        clk = 1'b0;
   logic        rst, start, pos_valid, press;
   logic [3:0]  pos, guess;
   logic [15:0] bunny_onehot;
   logic        hit, miss, game_over;
   logic [7:0]  score;
   logic [1:0]  lives;

   int checks = 0;
   int errors = 0;

   // Game model: mode 0 idle, 1 waiting for press, 2 showing hit, 3 showing miss, 4 game over.
   int m_mode, m_hold, m_target, m_score, m_lives;

   bunny_hit_judge dut (
      .clk(clk), .rst(rst), .start(start), .pos_valid(pos_valid), .pos(pos),
      .press(press), .guess(guess), .bunny_onehot(bunny_onehot), .hit(hit),
      .miss(miss), .score(score), .lives(lives), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int  old_t;
      bit  in_game;
      if (rst) begin
         m_mode = 0; m_target = 0; m_score = 0; m_lives = 3; m_hold = 0;
      end else begin
         old_t   = m_target;
         in_game = (m_mode >= 1 && m_mode <= 3);
         if (in_game && pos_valid) m_target = pos;
         if (start) begin
            m_mode = 1; m_score = 0; m_lives = 3; m_hold = 0;
         end else if (m_mode == 1 && press) begin
            m_hold = 4;
            if (guess == old_t) begin
               m_mode  = 2;
               m_score = (m_score < 255) ? m_score + 1 : 255;
            end else begin
               m_mode  = 3;
               m_lives = m_lives - 1;
            end
         end else if (m_mode == 2 || m_mode == 3) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) m_mode = (m_mode == 3 && m_lives == 0) ? 4 : 1;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic pv, input int p,
                      input logic pr, input int g);
      logic [15:0] exp_oh;
      rst = r; start = s; pos_valid = pv; pos = 4'(p); press = pr; guess = 4'(g);
      @(posedge clk);
      model_step();
      #1;
      exp_oh = (m_mode >= 1 && m_mode <= 3) ? (16'd1 << m_target) : 16'd0;
      check("onehot", 32'(bunny_onehot), 32'(exp_oh));
      check("hit", 32'(hit), 32'(m_mode == 2));
      check("miss", 32'(miss), 32'(m_mode == 3));
      check("game_over", 32'(game_over), 32'(m_mode == 4));
      check("score", 32'(score), 32'(m_score));
      check("lives", 32'(lives), 32'(m_lives));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pos_valid = 1'b0; pos = '0; press = 1'b0; guess = '0;
      m_mode = 0; m_hold = 0; m_target = 0; m_score = 0; m_lives = 3;

      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      idle(2);
      check("reset_lives", 32'(lives), 32'd3);
      check("reset_onehot", 32'(bunny_onehot), 32'd0);

      // Hit on position 5
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 5, 0, 0);
      check("onehot_pos5", 32'(bunny_onehot), 32'h0020);
      cyc(0, 0, 0, 0, 1, 5);
      check("hit_pulse", 32'(hit), 32'd1);
      check("score_one", 32'(score), 32'd1);
      idle(3);
      check("hit_still_high", 32'(hit), 32'd1);
      idle(1);
      check("hit_dropped", 32'(hit), 32'd0);

      // Three misses end the game
      cyc(0, 0, 1, 9, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 1, 2);
         check("miss_pulse", 32'(miss), 32'd1);
         cyc(0, 0, 0, 0, 1, 9);   // press during hold is ignored
         idle(3);
      end
      check("over_flag", 32'(game_over), 32'd1);
      check("over_lives", 32'(lives), 32'd0);
      check("over_onehot", 32'(bunny_onehot), 32'd0);
      cyc(0, 0, 1, 4, 1, 9);
      idle(2);
      cyc(0, 1, 0, 0, 0, 0);
      check("restart_score", 32'(score), 32'd0);
      check("restart_lives", 32'(lives), 32'd3);

      // Same-cycle press and move: judged against old target
      cyc(0, 0, 1, 3, 0, 0);
      cyc(0, 0, 1, 7, 1, 3);
      check("old_target_hit", 32'(hit), 32'd1);
      check("new_pos_onehot", 32'(bunny_onehot), 32'h0080);
      idle(4);

      // Score saturation
      for (int k = 0; k < 256; k++) begin
         cyc(0, 0, 0, 0, 1, 7);
         idle(4);
      end
      check("score_sat", 32'(score), 32'd255);
      cyc(0, 0, 0, 0, 1, 7);
      check("sat_hit", 32'(hit), 32'd1);
      check("sat_keep", 32'(score), 32'd255);
      idle(4);

      // Reset during a miss hold
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0);
      check("miss_lives2", 32'(lives), 32'd2);
      cyc(1, 0, 0, 0, 0, 0);
      check("rst_mid_miss", 32'(miss), 32'd0);
      check("rst_mid_lives", 32'(lives), 32'd3);
      check("rst_mid_onehot", 32'(bunny_onehot), 32'd0);
      idle(2);

      // Random play
      for (int i = 0; i < 1500; i++) begin
         int g;
         g = ($urandom_range(1, 0) == 1) ? m_target : int'($urandom_range(15, 0));
         cyc(($urandom_range(199, 0) == 0), ($urandom_range(39, 0) == 0),
             ($urandom_range(2, 0) == 0), int'($urandom_range(15, 0)),
             ($urandom_range(3, 0) == 0), g);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
